// File: rtl/riscv_fetch_unit.sv
// Instruction fetch front end: owns the PC, fetches over an imem req/gnt + rvalid
// bus and presents one instruction at a time to the core with a valid/ready handshake.
module riscv_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        misalign_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_HOLD,
    S_DRAIN
  } state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic        r_instr_valid;
  logic [31:0] r_instr;
  logic [31:0] r_instr_pc;
  logic        r_misalign_err;

  state_t      w_state_nxt;
  logic [31:0] w_pc_nxt;
  logic        w_instr_valid_nxt;
  logic [31:0] w_instr_nxt;
  logic [31:0] w_instr_pc_nxt;
  logic        w_misalign_err_nxt;

  // NOTE: sequential state uses non-blocking assignments only; the combinational
  // block below uses blocking ones, so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= S_IDLE;
      r_pc           <= RESET_PC;
      r_instr_valid  <= 1'b0;
      r_instr        <= NOP_INSTR;
      r_instr_pc     <= 32'h0;
      r_misalign_err <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_pc           <= w_pc_nxt;
      r_instr_valid  <= w_instr_valid_nxt;
      r_instr        <= w_instr_nxt;
      r_instr_pc     <= w_instr_pc_nxt;
      r_misalign_err <= w_misalign_err_nxt;
    end
  end

  // NOTE: every signal gets a hold-value default first, so no path leaves one
  // unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt        = r_state;
    w_pc_nxt           = r_pc;
    w_instr_valid_nxt  = r_instr_valid;
    w_instr_nxt        = r_instr;
    w_instr_pc_nxt     = r_instr_pc;
    w_misalign_err_nxt = r_misalign_err;

    if (redirect) begin
      // A redirect kills whatever is held; an issued-but-unanswered fetch must be drained.
      w_pc_nxt           = redirect_pc & ~32'h3;
      w_misalign_err_nxt = r_misalign_err | (redirect_pc[1:0] != 2'b00);
      w_instr_valid_nxt  = 1'b0;
      w_instr_nxt        = NOP_INSTR;
      case (r_state)
        S_REQ:   w_state_nxt = imem_gnt    ? S_DRAIN : S_REQ;
        S_WAIT:  w_state_nxt = imem_rvalid ? S_REQ   : S_DRAIN;
        S_DRAIN: w_state_nxt = imem_rvalid ? S_REQ   : S_DRAIN;
        default: w_state_nxt = S_REQ;
      endcase
    end else begin
      case (r_state)
        S_IDLE: w_state_nxt = S_REQ;
        S_REQ: begin
          if (imem_gnt) w_state_nxt = S_WAIT;
        end
        S_WAIT: begin
          if (imem_rvalid) begin
            w_instr_nxt       = imem_rdata;
            w_instr_pc_nxt    = r_pc;
            w_instr_valid_nxt = 1'b1;
            w_state_nxt       = S_HOLD;
          end
        end
        S_HOLD: begin
          if (instr_ready) begin
            w_pc_nxt          = r_pc + 32'd4;
            w_instr_valid_nxt = 1'b0;
            w_instr_nxt       = NOP_INSTR;
            w_state_nxt       = S_REQ;
          end
        end
        S_DRAIN: begin
          if (imem_rvalid) w_state_nxt = S_REQ;
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  assign imem_req     = (r_state == S_REQ);
  assign imem_addr    = r_pc;
  assign instr_valid  = r_instr_valid;
  assign instr        = r_instr;
  assign instr_pc     = r_instr_pc;
  assign misalign_err = r_misalign_err;

endmodule

// File: tb/tb_riscv_fetch_unit.sv
// Directed bench for riscv_fetch_unit: a table of per-cycle bus inputs with the
// outputs expected during that cycle, plus hand sequences for reset, wrap and redirect races.
module tb_riscv_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        misalign_err;

  int n_cmp = 0;
  int n_bad = 0;

  riscv_fetch_unit #(.RESET_PC(32'h0), .NOP_INSTR(NOP)) dut (
    .clk          (clk),
    .rst          (rst),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_gnt     (imem_gnt),
    .imem_rvalid  (imem_rvalid),
    .imem_rdata   (imem_rdata),
    .instr_valid  (instr_valid),
    .instr        (instr),
    .instr_pc     (instr_pc),
    .instr_ready  (instr_ready),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .misalign_err (misalign_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        ready;
    logic        redir;
    logic [31:0] rpc;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_instr;
    logic [31:0] e_ipc;
    logic        e_mis;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic gnt, logic rvalid, logic [31:0] rdata, logic ready,
                              logic redir, logic [31:0] rpc, logic e_req, logic [31:0] e_addr,
                              logic e_valid, logic [31:0] e_instr, logic [31:0] e_ipc,
                              logic e_mis);
    vec_t v;
    v.gnt = gnt; v.rvalid = rvalid; v.rdata = rdata; v.ready = ready;
    v.redir = redir; v.rpc = rpc; v.e_req = e_req; v.e_addr = e_addr;
    v.e_valid = e_valid; v.e_instr = e_instr; v.e_ipc = e_ipc; v.e_mis = e_mis;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic gnt, input logic rvalid, input logic [31:0] rdata,
                       input logic ready, input logic redir, input logic [31:0] rpc);
    imem_gnt    = gnt;
    imem_rvalid = rvalid;
    imem_rdata  = rdata;
    instr_ready = ready;
    redirect    = redir;
    redirect_pc = rpc;
  endtask

  task automatic expect_out(input string tag, input logic req, input logic [31:0] addr,
                            input logic valid, input logic [31:0] ins, input logic [31:0] ipc,
                            input logic mis);
    check({tag, ".req"},   {31'h0, imem_req},     {31'h0, req});
    check({tag, ".addr"},  imem_addr,             addr);
    check({tag, ".valid"}, {31'h0, instr_valid},  {31'h0, valid});
    check({tag, ".instr"}, instr,                 ins);
    check({tag, ".ipc"},   instr_pc,              ipc);
    check({tag, ".mis"},   {31'h0, misalign_err}, {31'h0, mis});
  endtask

  task automatic wait_valid(input int budget);
    logic found = 1'b0;
    for (int k = 0; k < budget; k++) begin
      if (instr_valid) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("wait_valid", {31'h0, found}, 32'h1);
  endtask

  initial begin
    // Inputs are driven on the falling edge; outputs are compared in the same
    // half-cycle, reflecting the state produced by the preceding rising edge.
    //                 gnt rv rdata          rdy rd rpc            req addr          vld instr          ipc            mis
    vecs.push_back(mk(0, 0, 32'h0,          0, 0, 32'h0,        0, 32'h0,        0, NOP,          32'h0,         0)); // IDLE after reset
    vecs.push_back(mk(1, 0, 32'h0,          0, 0, 32'h0,        1, 32'h0,        0, NOP,          32'h0,         0));
    vecs.push_back(mk(0, 1, 32'h0050_0093,  0, 0, 32'h0,        0, 32'h0,        0, NOP,          32'h0,         0));
    vecs.push_back(mk(0, 0, 32'h0,          1, 0, 32'h0,        0, 32'h0,        1, 32'h0050_0093, 32'h0,        0));
    vecs.push_back(mk(1, 0, 32'h0,          0, 0, 32'h0,        1, 32'h4,        0, NOP,          32'h0,         0));
    vecs.push_back(mk(0, 1, 32'h0010_0113,  0, 0, 32'h0,        0, 32'h4,        0, NOP,          32'h0,         0));
    for (int i = 0; i < 5; i++)  // backpressure
      vecs.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,        0, 32'h4,        1, 32'h0010_0113, 32'h4,        0));
    vecs.push_back(mk(0, 0, 32'h0,          1, 0, 32'h0,        0, 32'h4,        1, 32'h0010_0113, 32'h4,        0));
    for (int i = 0; i < 3; i++)  // grant withheld
      vecs.push_back(mk(0, 0, 32'h0,        0, 0, 32'h0,        1, 32'h8,        0, NOP,          32'h4,         0));
    vecs.push_back(mk(1, 0, 32'h0,          0, 0, 32'h0,        1, 32'h8,        0, NOP,          32'h4,         0));
    vecs.push_back(mk(0, 1, 32'h0020_8193,  0, 0, 32'h0,        0, 32'h8,        0, NOP,          32'h4,         0));
    vecs.push_back(mk(0, 0, 32'h0,          1, 0, 32'h0,        0, 32'h8,        1, 32'h0020_8193, 32'h8,        0));
    vecs.push_back(mk(1, 0, 32'h0,          0, 0, 32'h0,        1, 32'hC,        0, NOP,          32'h8,         0));
    vecs.push_back(mk(0, 0, 32'h0,          0, 1, 32'h100,      0, 32'hC,        0, NOP,          32'h8,         0)); // redirect in WAIT
    vecs.push_back(mk(0, 0, 32'h0,          0, 0, 32'h0,        0, 32'h100,      0, NOP,          32'h8,         0));
    vecs.push_back(mk(0, 1, 32'hDEAD_BEEF,  0, 0, 32'h0,        0, 32'h100,      0, NOP,          32'h8,         0));
    vecs.push_back(mk(1, 0, 32'h0,          0, 0, 32'h0,        1, 32'h100,      0, NOP,          32'h8,         0));
    vecs.push_back(mk(0, 1, 32'h1111_1111,  0, 0, 32'h0,        0, 32'h100,      0, NOP,          32'h8,         0));
    vecs.push_back(mk(0, 0, 32'h0,          1, 1, 32'h40,       0, 32'h100,      1, 32'h1111_1111, 32'h100,      0)); // redirect vs retire
    vecs.push_back(mk(0, 0, 32'h0,          0, 1, 32'h102,      1, 32'h40,       0, NOP,          32'h100,       0)); // misaligned, REQ no gnt
    vecs.push_back(mk(1, 0, 32'h0,          0, 0, 32'h0,        1, 32'h100,      0, NOP,          32'h100,       1));
    vecs.push_back(mk(0, 1, 32'h2222_2222,  0, 0, 32'h0,        0, 32'h100,      0, NOP,          32'h100,       1));
    vecs.push_back(mk(0, 0, 32'h0,          1, 0, 32'h0,        0, 32'h100,      1, 32'h2222_2222, 32'h100,      1));
    vecs.push_back(mk(0, 0, 32'h0,          0, 0, 32'h0,        1, 32'h104,      0, NOP,          32'h100,       1));

    rst = 1'b1;
    drive(0, 0, 32'h0, 0, 0, 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      if (i > 0) @(negedge clk);
      drive(vecs[i].gnt, vecs[i].rvalid, vecs[i].rdata, vecs[i].ready, vecs[i].redir, vecs[i].rpc);
      expect_out($sformatf("vec%0d", i), vecs[i].e_req, vecs[i].e_addr, vecs[i].e_valid,
                 vecs[i].e_instr, vecs[i].e_ipc, vecs[i].e_mis);
    end

    // Reset clears the sticky error and restores the PC.
    @(negedge clk);
    rst = 1'b1;
    drive(0, 0, 32'h0, 0, 0, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    expect_out("rst2", 0, 32'h0, 0, NOP, 32'h0, 0);
    @(negedge clk);
    expect_out("rst2_req", 1, 32'h0, 0, NOP, 32'h0, 0);

    // Redirect on the granting cycle must drain, then wrap 0xFFFF_FFFC + 4 to 0.
    drive(1, 0, 32'h0, 0, 1, 32'hFFFF_FFFE);
    @(negedge clk);
    expect_out("drain", 0, 32'hFFFF_FFFC, 0, NOP, 32'h0, 1);
    drive(0, 1, 32'h5555_5555, 0, 0, 32'h0);
    @(negedge clk);
    expect_out("wrap_req", 1, 32'hFFFF_FFFC, 0, NOP, 32'h0, 1);
    drive(1, 0, 32'h0, 0, 0, 32'h0);
    @(negedge clk);
    drive(0, 1, 32'h3333_3333, 0, 0, 32'h0);
    @(negedge clk);
    drive(0, 0, 32'h0, 1, 0, 32'h0);
    wait_valid(8);
    check("wrap.instr", instr, 32'h3333_3333);
    check("wrap.ipc", instr_pc, 32'hFFFF_FFFC);
    @(negedge clk);
    drive(0, 0, 32'h0, 0, 0, 32'h0);
    expect_out("wrap_next", 1, 32'h0, 0, NOP, 32'hFFFF_FFFC, 1);

    // Redirect coinciding with the response: data dropped, straight back to REQ.
    drive(1, 0, 32'h0, 0, 0, 32'h0);
    @(negedge clk);
    drive(0, 1, 32'h4444_4444, 0, 1, 32'h80);
    @(negedge clk);
    drive(0, 0, 32'h0, 0, 0, 32'h0);
    expect_out("race", 1, 32'h80, 0, NOP, 32'hFFFF_FFFC, 1);
    @(negedge clk);
    expect_out("race_hold", 1, 32'h80, 0, NOP, 32'hFFFF_FFFC, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
